rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N_MASTERS, 2, number of requesting masters sharing one slave port (legal range 1..16).
REQ-002 Parameter TO_W, 8, width of the timeout counter.
REQ-003 Parameter TIMEOUT, 255, busy-cycle limit before forced release; 0 disables the timeout.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 m_valid  in  N_MASTERS  per-master request valid.
REQ-007 s_ready  in  1  slave completion strobe for the granted transaction.
REQ-008 grant  out  N_MASTERS  one-hot registered grant; all-zero when idle.
REQ-009 sel  out  Nb  registered index of the granted master; Nb = max(1, clog2(N_MASTERS)).
REQ-010 s_valid  out  1  gated request to slave = OR(m_valid AND grant).
REQ-011 m_ready  out  N_MASTERS  s_ready routed to granted master only = grant AND {N_MASTERS{s_ready}}.
REQ-012 busy  out  1  high while in BUSY.
REQ-013 err  out  1  one-cycle pulse on timeout release.

Function
REQ-014 Two states, IDLE and BUSY; IDLE on reset.
REQ-015 IDLE: grant all-zero, s_valid 0, m_ready all-zero, busy 0.
REQ-016 IDLE with any m_valid bit set: the master picked by rotating priority becomes the registered grant/sel, and the state moves to BUSY on the next edge (1-cycle grant latency).
REQ-017 Rotating priority: the search starts at index ptr and wraps N_MASTERS-1 -> 0; the first set m_valid bit wins.
REQ-018 BUSY: grant and sel held constant regardless of m_valid changes; a granted master dropping valid does not release the grant.
REQ-019 BUSY and s_ready=1: transaction complete; ptr <= sel+1 (wrap to 0 after N_MASTERS-1); state -> IDLE; this costs one mandatory idle cycle between grants.
REQ-020 s_ready=1 in IDLE is ignored; no state, ptr or output change.
REQ-021 Timeout counter cleared on IDLE->BUSY and incremented each BUSY cycle without s_ready.
REQ-022 When the counter reaches TIMEOUT (TIMEOUT != 0) with s_ready=0: err=1 for one cycle; state -> IDLE; ptr <= sel+1.
REQ-023 s_ready and the timeout in the same cycle: completion wins and err stays 0.
REQ-024 Counter saturates at 2^TO_W-1 and never wraps; TIMEOUT > 2^TO_W-1 is illegal.
REQ-025 N_MASTERS=1: sel is constant 0 and ptr is constant 0; the state behaviour is unchanged.
REQ-026 No master is starved: any continuously asserting master is granted within N_MASTERS grants.

Reset
REQ-027 Asserting rst at any time, including mid-BUSY, forces on the same cycle: state IDLE, grant 0, sel 0, ptr 0, counter 0, err 0, busy 0.
REQ-028 On rst, s_valid and m_ready go to 0 combinationally through grant=0.
REQ-029 After rst deasserts, the first arbitration starts at index 0.

Structure
REQ-030 The state encodings (IDLE=0, BUSY=1) and the Nb width expression live in the shared interconnect header.
REQ-031 Sub-module rr_pick (combinational: m_valid, ptr -> one-hot pick, index, any) performs the rotating search.
REQ-032 rr_arbiter holds all registers; grant/sel outputs connect directly to the merge datapath select.

Verification (N_MASTERS=4, TIMEOUT=8)
REQ-033 Single request: m_valid=0100 at t0 -> grant=0100, sel=2, busy=1 at t1; s_ready at t3 -> m_ready=0100 at t3, IDLE at t4.
REQ-034 Fairness: m_valid=1111 held, s_ready one cycle after each grant -> grant order 0001, 0010, 0100, 1000, 0001.
REQ-035 Wrap: ptr=3 (after granting master 2), m_valid=0011 -> grant=0001.
REQ-036 Timeout: grant master 1, s_ready never asserted -> err=1 exactly 8 BUSY cycles after grant, then IDLE; next grant searches from index 2.
REQ-037 Collision: s_ready=1 on the timeout cycle -> err=0, normal completion, ptr advanced once.
REQ-038 Reset mid-op: rst pulse while BUSY with grant=1000 -> grant=0, busy=0 immediately; m_valid=1001 after release -> grant=0001.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared interconnect definitions for the round-robin arbiter: state encoding and select width.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package rr_arbiter_pkg;

    // Arbiter states; IDLE must stay 0 so a cleared register means idle
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } rr_state_t;

    // Width of the master index: a single master still gets a 1-bit select
    function automatic int rr_sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Rotating-priority search: first set request at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
module rr_pick #(
    parameter int N  = 2,
    parameter int NB = 1
) (
    input  logic [N-1:0]  req,
    input  logic [NB-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [NB-1:0] idx,
    output logic          any
);

    // Walk the request vector starting at ptr; the first hit owns the pick
    always_comb begin
        int j;
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        j    = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any     = 1'b1;
                pick[j] = 1'b1;
                idx     = NB'(j);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter granting one master at a time onto a shared slave port, with timeout release.
// Latency: grant registered one cycle after a request is seen in IDLE; one idle cycle between grants.
// Backpressure: grant held until s_ready completes the transfer or the busy-cycle limit forces release.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int TO_W      = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_MASTERS-1:0]                m_valid,
    input  logic                                s_ready,
    output logic [N_MASTERS-1:0]                grant,
    output logic [rr_sel_w(N_MASTERS)-1:0]      sel,
    output logic                                s_valid,
    output logic [N_MASTERS-1:0]                m_ready,
    output logic                                busy,
    output logic                                err
);

    localparam int              NB      = rr_sel_w(N_MASTERS);
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0] TO_VAL  = TO_W'(TIMEOUT);

    rr_state_t              state, state_nxt;
    logic [N_MASTERS-1:0]   grant_nxt;
    logic [NB-1:0]          sel_nxt;
    logic [NB-1:0]          ptr, ptr_nxt, ptr_inc;
    logic [TO_W-1:0]        cnt, cnt_nxt;
    logic [N_MASTERS-1:0]   pick_oh;
    logic [NB-1:0]          pick_idx;
    logic                   pick_any;
    logic                   timeout_hit;

    rr_pick #(
        .N  (N_MASTERS),
        .NB (NB)
    ) u_pick (
        .req  (m_valid),
        .ptr  (ptr),
        .pick (pick_oh),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Priority moves to the master after the one just served
    assign ptr_inc     = (sel == NB'(N_MASTERS - 1)) ? '0 : sel + 1'b1;
    assign timeout_hit = TO_EN && (cnt == TO_VAL);

    // Next-state: grant on any request in IDLE, release on completion or timeout in BUSY
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = BUSY;
                    grant_nxt = pick_oh;
                    sel_nxt   = pick_idx;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (s_ready || timeout_hit) begin
                    // Completion takes precedence, so err only fires without s_ready
                    err       = !s_ready;
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    sel_nxt   = '0;
                    ptr_nxt   = ptr_inc;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant, select, priority pointer and busy-cycle counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign s_valid = |(m_valid & grant);
    assign m_ready = grant & {N_MASTERS{s_ready}};
    assign busy    = (state == BUSY);

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] m_valid;
    logic       s_ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       s_valid;
    logic [3:0] m_ready;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the port, where the next search starts, busy cycles so far
    bit mb;
    int msel;
    int mptr;
    int mcnt;
    logic seen_err;

    rr_arbiter #(
        .N_MASTERS (N),
        .TO_W      (8),
        .TIMEOUT   (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_valid (m_valid),
        .s_ready (s_ready),
        .grant   (grant),
        .sel     (sel),
        .s_valid (s_valid),
        .m_ready (m_ready),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mb   = 1'b0;
        msel = 0;
        mptr = 0;
        mcnt = 0;
    endtask

    // One clock: drive inputs, compare against the model mid-cycle, then advance the model
    task automatic cycle(input logic [3:0] mv, input logic sr);
        logic [3:0] eg;
        logic [3:0] emr;
        bit         found;
        m_valid = mv;
        s_ready = sr;
        @(negedge clk);
        eg  = mb ? 4'(1 << msel) : 4'b0000;
        emr = (mb && sr) ? eg : 4'b0000;
        chk("grant", grant, eg);
        if (mb) chk("sel", sel, msel);
        chk("s_valid", s_valid, mb && mv[msel]);
        chk("m_ready", m_ready, emr);
        chk("busy", busy, mb);
        chk("err", err, mb && !sr && (mcnt == TO));
        seen_err = err;
        @(posedge clk);
        if (!mb) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && mv[(mptr + k) % N]) begin
                    found = 1'b1;
                    msel  = (mptr + k) % N;
                end
            end
            if (found) begin
                mb   = 1'b1;
                mcnt = 0;
            end
        end else if (sr || mcnt == TO) begin
            mb   = 1'b0;
            mptr = (msel + 1) % N;
        end else if (mcnt < 255) begin
            mcnt++;
        end
        #1;
    endtask

    initial begin
        logic [3:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        rst     = 1'b1;
        m_valid = '0;
        s_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_s_valid", s_valid, 0);
        rst = 1'b0;

        // Fairness: all masters requesting, completion one cycle after each grant
        for (int g = 0; g < 5; g++) begin
            cycle(4'b1111, 1'b0);
            chk("fair_order", grant, order[g]);
            cycle(4'b1111, 1'b1);
        end

        // Single request for master 2; valid drops after the grant, completion two cycles later
        cycle(4'b0100, 1'b0);
        chk("single_grant", grant, 4'b0100);
        chk("single_sel", sel, 2);
        chk("single_busy", busy, 1);
        cycle(4'b0000, 1'b0);
        chk("single_hold", grant, 4'b0100);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b1);
        chk("single_idle", busy, 0);

        // Wrap: pointer at 3, masters 0 and 1 requesting
        cycle(4'b0011, 1'b0);
        chk("wrap_grant", grant, 4'b0001);
        cycle(4'b0011, 1'b1);

        // s_ready while idle changes nothing
        cycle(4'b0000, 1'b1);
        chk("idle_ready_busy", busy, 0);

        // Timeout: master 1 granted, never completed
        cycle(4'b0010, 1'b0);
        chk("to_grant", grant, 4'b0010);
        for (int k = 0; k <= TO; k++) begin
            cycle(4'b0010, 1'b0);
            chk("to_err_pulse", seen_err, (k == TO));
        end
        chk("to_idle", busy, 0);

        // Search now starts at 2, so master 3 wins over masters 0 and 1
        cycle(4'b1011, 1'b0);
        chk("to_next_grant", grant, 4'b1000);

        // Collision: completion lands on the timeout cycle
        for (int k = 0; k < TO; k++) cycle(4'b1011, 1'b0);
        cycle(4'b1011, 1'b1);
        chk("coll_err", seen_err, 0);
        chk("coll_idle", busy, 0);
        cycle(4'b0110, 1'b0);
        chk("coll_ptr", grant, 4'b0010);
        cycle(4'b0000, 1'b1);

        // Reset in the middle of a grant to master 3
        cycle(4'b1000, 1'b0);
        chk("mid_grant", grant, 4'b1000);
        #2;
        rst     = 1'b1;
        s_ready = 1'b1;
        #1;
        chk("mid_rst_grant", grant, 4'b0000);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_s_valid", s_valid, 0);
        chk("mid_rst_m_ready", m_ready, 4'b0000);
        chk("mid_rst_err", err, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        s_ready = 1'b0;
        cycle(4'b1001, 1'b0);
        chk("post_rst_grant", grant, 4'b0001);
        cycle(4'b1001, 1'b1);

        // Random traffic against the model; sparse s_ready lets timeouts occur
        for (int c = 0; c < 400; c++) begin
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
